// File: rtl/sweep_package.sv
// Shared widths, state codes and counter defaults for the link-parameter sweep sequencer.

package tx_package;
    localparam int TX_SETTING_WIDTH = 4;
endpackage

package rx_package;
    localparam int RX_SETTING_WIDTH = 5;
endpackage

package sweep_package;
    localparam int CNT_WIDTH_DEF = 32;

    // Sweep sequencer state codes, kept as plain constants so older tools can consume them.
    typedef logic [2:0] sweep_state_t;

    localparam sweep_state_t ST_IDLE   = 3'd0;
    localparam sweep_state_t ST_RESET  = 3'd1;
    localparam sweep_state_t ST_RUN    = 3'd2;
    localparam sweep_state_t ST_REPORT = 3'd3;
    localparam sweep_state_t ST_NEXT   = 3'd4;
    localparam sweep_state_t ST_DONE   = 3'd5;
endpackage

// File: rtl/sweep_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.

module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled events, stop at all-ones, clear takes priority.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep sequencer: steps tx (outer) and rx (inner) settings, resets the emulated
// link per point, counts bits/errors until the time trigger, and hands out records.
//
// state  | meaning
// IDLE   | waiting for start, link held in reset
// RESET  | link in reset for RST_CYCLES, counters cleared
// RUN    | link released, lock-in then count bits/errors until time_flag
// REPORT | record presented on res_*, waiting for res_ready
// NEXT   | advance rx, then tx; decide RESET or DONE
// DONE   | sweep finished, link held in reset until start/abort

module sweep_ctrl
    import sweep_package::*;
    import tx_package::*;
    import rx_package::*;
#(
    parameter int RST_CYCLES = 16,
    parameter int FLAG_GUARD = 4,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [TX_SETTING_WIDTH-1:0] tx_first,
    input  logic [TX_SETTING_WIDTH-1:0] tx_last,
    input  logic [RX_SETTING_WIDTH-1:0] rx_first,
    input  logic [RX_SETTING_WIDTH-1:0] rx_last,
    input  logic [CNT_WIDTH-1:0]        lock_bits,
    input  logic                        time_flag,
    input  logic                        bit_valid,
    input  logic                        bit_err,
    output logic                        rst_dut,
    output logic [TX_SETTING_WIDTH-1:0] tx_setting,
    output logic [RX_SETTING_WIDTH-1:0] rx_setting,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [TX_SETTING_WIDTH-1:0] res_tx,
    output logic [RX_SETTING_WIDTH-1:0] res_rx,
    output logic [CNT_WIDTH-1:0]        res_bits,
    output logic [CNT_WIDTH-1:0]        res_errs,
    output logic                        busy,
    output logic                        done
);

    // One down-counter serves both the reset hold and the post-release flag guard.
    localparam int TMR_MAX = (RST_CYCLES > FLAG_GUARD) ? RST_CYCLES : FLAG_GUARD;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] RST_LOAD   = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] GUARD_LOAD = TMR_W'(FLAG_GUARD);

    sweep_state_t                state;
    sweep_state_t                state_nxt;
    logic [TMR_W-1:0]            tmr;
    logic [TX_SETTING_WIDTH-1:0] tx_first_q;
    logic [TX_SETTING_WIDTH-1:0] tx_last_q;
    logic [RX_SETTING_WIDTH-1:0] rx_first_q;
    logic [RX_SETTING_WIDTH-1:0] rx_last_q;
    logic [CNT_WIDTH-1:0]        lock_cnt;
    logic                        sweep_go;
    logic                        rx_more;
    logic                        tx_more;
    logic                        cnt_clr;
    logic                        locking;
    logic                        lock_en;
    logic                        bit_en;
    logic                        err_en;

    assign sweep_go = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
    assign rx_more  = rx_setting < rx_last_q;
    assign tx_more  = tx_setting < tx_last_q;

    // Next-state decode; abort overrides everything, including a simultaneous start.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = ST_RESET;
            ST_RESET:  if (tmr == '0) state_nxt = ST_RUN;
            ST_RUN:    if ((tmr == '0) && time_flag) state_nxt = ST_REPORT;
            ST_REPORT: if (res_ready) state_nxt = ST_NEXT;
            ST_NEXT:   state_nxt = (rx_more || tx_more) ? ST_RESET : ST_DONE;
            ST_DONE:   if (start) state_nxt = ST_RESET;
            default:   state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    // State register and the status outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rst_dut   <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rst_dut   <= (state_nxt != ST_RUN);
            res_valid <= (state_nxt == ST_REPORT);
            busy      <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
            done      <= (state_nxt == ST_DONE);
        end
    end

    // Reset-hold / flag-guard timer, loaded on entry to RESET and RUN, counts down to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmr <= '0;
        end else if ((state_nxt == ST_RESET) && (state != ST_RESET)) begin
            tmr <= RST_LOAD;
        end else if ((state_nxt == ST_RUN) && (state != ST_RUN)) begin
            tmr <= GUARD_LOAD;
        end else if (tmr != '0) begin
            tmr <= tmr - 1'b1;
        end
    end

    // Range capture at sweep start; a reversed range collapses to its first point.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_first_q <= '0;
            tx_last_q  <= '0;
            rx_first_q <= '0;
            rx_last_q  <= '0;
        end else if (sweep_go) begin
            tx_first_q <= tx_first;
            tx_last_q  <= (tx_last < tx_first) ? tx_first : tx_last;
            rx_first_q <= rx_first;
            rx_last_q  <= (rx_last < rx_first) ? rx_first : rx_last;
        end
    end

    // Point stepping: rx is the inner loop; settings only move into a RESET state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_setting <= '0;
            rx_setting <= '0;
        end else if (sweep_go) begin
            tx_setting <= tx_first;
            rx_setting <= rx_first;
        end else if ((state == ST_NEXT) && !abort) begin
            if (rx_more) begin
                rx_setting <= rx_setting + 1'b1;
            end else if (tx_more) begin
                rx_setting <= rx_first_q;
                tx_setting <= tx_setting + 1'b1;
            end
        end
    end

    assign cnt_clr = abort || (state == ST_RESET);
    assign locking = lock_cnt < lock_bits;
    assign lock_en = (state == ST_RUN) && bit_valid && locking;
    assign bit_en  = (state == ST_RUN) && bit_valid && !locking;
    assign err_en  = bit_en && bit_err;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_lock_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (lock_en),
        .count (lock_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (bit_en),
        .count (res_bits)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .en    (err_en),
        .count (res_errs)
    );

    // Counters and settings are frozen outside RUN/NEXT, so they double as the record.
    assign res_tx = tx_setting;
    assign res_rx = rx_setting;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Bench for sweep_ctrl: a 32-bit and a 4-bit counter instance run in lockstep on the
// same stimulus; a reference model predicts each point's record into a scoreboard
// that a separate monitor drains on every accepted handshake.

module tb_sweep_ctrl;
    import tx_package::*;
    import rx_package::*;

    localparam int RST_CYC = 16;
    localparam int FG      = 4;
    localparam int CW      = 32;
    localparam int SW      = 4;

    localparam int P_RAND  = 0;
    localparam int P_DIR   = 1;
    localparam int P_STALE = 2;
    localparam int P_ERRS  = 3;

    localparam int R_ALWAYS = 0;
    localparam int R_RAND   = 1;
    localparam int R_HOLD7  = 2;
    localparam int R_NEVER  = 3;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        start;
    logic                        abort;
    logic [TX_SETTING_WIDTH-1:0] tx_first, tx_last;
    logic [RX_SETTING_WIDTH-1:0] rx_first, rx_last;
    logic [CW-1:0]               lock_bits;
    logic                        time_flag, bit_valid, bit_err;
    logic                        rst_dut;
    logic [TX_SETTING_WIDTH-1:0] tx_setting, res_tx;
    logic [RX_SETTING_WIDTH-1:0] rx_setting, res_rx;
    logic                        res_valid, res_ready;
    logic [CW-1:0]               res_bits, res_errs;
    logic                        busy, done;

    logic                        s_rst_dut, s_res_valid, s_busy, s_done;
    logic [TX_SETTING_WIDTH-1:0] s_tx_setting, s_res_tx;
    logic [RX_SETTING_WIDTH-1:0] s_rx_setting, s_res_rx;
    logic [SW-1:0]               s_res_bits, s_res_errs;

    typedef struct {
        longint unsigned tx;
        longint unsigned rx;
        longint unsigned bits;
        longint unsigned errs;
        longint unsigned sbits;
        longint unsigned serrs;
    } rec_t;

    rec_t sb[$];
    int   tests      = 0;
    int   fails      = 0;
    int   cyc        = 0;
    int   acc_cyc    = 0;
    int   start_cyc  = 0;
    int   ready_mode = R_ALWAYS;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    sweep_ctrl #(.RST_CYCLES(RST_CYC), .FLAG_GUARD(FG), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .tx_first(tx_first), .tx_last(tx_last), .rx_first(rx_first), .rx_last(rx_last),
        .lock_bits(lock_bits), .time_flag(time_flag), .bit_valid(bit_valid), .bit_err(bit_err),
        .rst_dut(rst_dut), .tx_setting(tx_setting), .rx_setting(rx_setting),
        .res_valid(res_valid), .res_ready(res_ready), .res_tx(res_tx), .res_rx(res_rx),
        .res_bits(res_bits), .res_errs(res_errs), .busy(busy), .done(done)
    );

    sweep_ctrl #(.RST_CYCLES(RST_CYC), .FLAG_GUARD(FG), .CNT_WIDTH(SW)) dut_small (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .tx_first(tx_first), .tx_last(tx_last), .rx_first(rx_first), .rx_last(rx_last),
        .lock_bits(lock_bits[SW-1:0]), .time_flag(time_flag), .bit_valid(bit_valid), .bit_err(bit_err),
        .rst_dut(s_rst_dut), .tx_setting(s_tx_setting), .rx_setting(s_rx_setting),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_tx(s_res_tx), .res_rx(s_res_rx),
        .res_bits(s_res_bits), .res_errs(s_res_errs), .busy(s_busy), .done(s_done)
    );

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s timed out (cycle %0d)", nm, cyc);
    endtask

    function automatic longint unsigned sat_inc(input longint unsigned x, input int w);
        longint unsigned m;
        m = (64'd1 << w) - 64'd1;
        return (x >= m) ? x : x + 64'd1;
    endfunction

    task automatic idle_inputs();
        bit_valid = 1'b0;
        bit_err   = 1'b0;
        time_flag = 1'b0;
    endtask

    // Consumer handshake pattern, selectable per sweep.
    initial begin
        int hold;
        hold = 0;
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            hold = res_valid ? hold + 1 : 0;
            case (ready_mode)
                R_ALWAYS: res_ready = 1'b1;
                R_RAND:   res_ready = ($urandom_range(0, 2) != 0);
                R_HOLD7:  res_ready = (hold > 7);
                default:  res_ready = 1'b0;
            endcase
        end
    end

    // Monitor: drains the scoreboard on handshakes, checks hold stability and setting stability.
    initial begin
        logic                  p_hold, p_abort, p_run;
        logic [CW-1:0]         p_bits;
        logic [63:0]           p_misc;
        rec_t                  r;
        p_hold = 1'b0; p_abort = 1'b0; p_run = 1'b0; p_bits = '0; p_misc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (res_valid && res_ready) begin
                    acc_cyc = cyc + 1;
                    if (sb.size() == 0) begin
                        timeout("unexpected_record");
                    end else begin
                        r = sb.pop_front();
                        chk("rec_tx", res_tx, r.tx);
                        chk("rec_rx", res_rx, r.rx);
                        chk("rec_bits", res_bits, r.bits);
                        chk("rec_errs", res_errs, r.errs);
                        chk("rec_small_valid", s_res_valid, 1);
                        chk("rec_small_bits", s_res_bits, r.sbits);
                        chk("rec_small_errs", s_res_errs, r.serrs);
                    end
                end
                if (p_hold && !p_abort) begin
                    chk("hold_valid", res_valid, 1);
                    chk("hold_bits", res_bits, p_bits);
                    chk("hold_misc", {res_tx, res_rx, tx_setting, rx_setting, res_errs}, p_misc);
                end
                if (p_run && !rst_dut) begin
                    chk("run_settings_stable", {tx_setting, rx_setting}, p_misc[CW +: 9]);
                end
            end
            p_hold  = res_valid && !res_ready;
            p_abort = abort;
            p_run   = !rst_dut;
            p_bits  = res_bits;
            p_misc  = 64'({res_tx, res_rx, tx_setting, rx_setting, res_errs});
        end
    end

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            if (!rst_dut) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_run");
    endtask

    // Drives one RUN window and predicts the record from the bit stream actually applied.
    task automatic drive_point(input int pmode, input int lb, input int ptx, input int prx);
        longint unsigned lock, b, er, sbits, serrs;
        int  c, n;
        bit  v, e, f, fin;
        rec_t r;
        lock = 0; b = 0; er = 0; sbits = 0; serrs = 0;
        c = 0; fin = 1'b0;
        n = $urandom_range(FG + 1, 40);
        while (!fin) begin
            case (pmode)
                P_DIR: begin
                    v = 1'b1; e = (c == 19) || (c == 49) || (c == 89); f = (c == 99);
                end
                P_STALE: begin
                    v = ($urandom_range(0, 1) == 1); e = ($urandom_range(0, 3) == 0);
                    f = (c < FG) || (c >= FG + 6);
                end
                P_ERRS: begin
                    v = 1'b1; e = 1'b1; f = (c == 19);
                end
                default: begin
                    v = ($urandom_range(0, 3) != 0); e = ($urandom_range(0, 4) == 0);
                    f = (c == n - 1) || ((c < FG) && ($urandom_range(0, 1) == 1));
                end
            endcase
            bit_valid = v;
            bit_err   = e;
            time_flag = f;
            if (v) begin
                if (lock < longint'(lb)) begin
                    lock++;
                end else begin
                    b     = sat_inc(b, CW);
                    sbits = sat_inc(sbits, SW);
                    if (e) begin
                        er    = sat_inc(er, CW);
                        serrs = sat_inc(serrs, SW);
                    end
                end
            end
            if ((c >= FG) && f) begin
                fin = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                c++;
                if (c == 1) chk("busy_run", busy, 1);
                if (c > 300) begin
                    timeout("drive_point");
                    fin = 1'b1;
                end
            end
        end
        r.tx = ptx; r.rx = prx; r.bits = b; r.errs = er; r.sbits = sbits; r.serrs = serrs;
        sb.push_back(r);
    endtask

    task automatic abort_in_report();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            if (res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_report");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_rst_dut", rst_dut, 1);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_errs_clear", res_errs, 0);
        chk("abort_small_valid", s_res_valid, 0);
        if (sb.size() > 0) void'(sb.pop_back());
    endtask

    task automatic run_sweep(input int tf, input int tl, input int rf, input int rl,
                             input int lb, input int pmode, input int rmode, input bit do_abort);
        int ptx[$], prx[$];
        int etl, erl;
        bit ok;
        etl = (tl < tf) ? tf : tl;
        erl = (rl < rf) ? rf : rl;
        for (int t = tf; t <= etl; t++) begin
            for (int r = rf; r <= erl; r++) begin
                ptx.push_back(t);
                prx.push_back(r);
            end
        end
        ready_mode = rmode;
        tx_first = TX_SETTING_WIDTH'(tf); tx_last = TX_SETTING_WIDTH'(tl);
        rx_first = RX_SETTING_WIDTH'(rf); rx_last = RX_SETTING_WIDTH'(rl);
        lock_bits = CW'(lb);
        start = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_rst_dut", rst_dut, 1);
        chk("start_tx", tx_setting, tf);
        chk("start_rx", rx_setting, rf);
        tx_first = TX_SETTING_WIDTH'($urandom); tx_last = TX_SETTING_WIDTH'($urandom);
        rx_first = RX_SETTING_WIDTH'($urandom); rx_last = RX_SETTING_WIDTH'($urandom);
        for (int p = 0; p < ptx.size(); p++) begin
            wait_run(ok);
            if (!ok) return;
            chk("run_latency", cyc, (p == 0) ? start_cyc + RST_CYC : acc_cyc + 1 + RST_CYC);
            chk("run_tx", tx_setting, ptx[p]);
            chk("run_rx", rx_setting, prx[p]);
            drive_point(pmode, lb, ptx[p], prx[p]);
            if (do_abort) begin
                abort_in_report();
                return;
            end
        end
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            idle_inputs();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_done");
        chk("done_busy", busy, 0);
        chk("done_rst_dut", rst_dut, 1);
        chk("done_small", s_done, 1);
        chk("done_all_records", sb.size(), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        tx_first = '0; tx_last = '0; rx_first = '0; rx_last = '0; lock_bits = '0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst_dut", rst_dut, 1);
        chk("reset_tx", tx_setting, 0);
        chk("reset_rx", rx_setting, 0);
        chk("reset_res_valid", res_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_res_bits", res_bits, 0);
        chk("reset_res_errs", res_errs, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_sweep(2, 2, 5, 5, 10, P_DIR, R_ALWAYS, 1'b0);
        run_sweep(0, 1, 4, 6, $urandom_range(0, 6), P_RAND, R_ALWAYS, 1'b0);
        run_sweep(1, 1, 2, 3, 3, P_RAND, R_HOLD7, 1'b0);
        run_sweep(0, 0, 1, 1, 2, P_STALE, R_ALWAYS, 1'b0);
        run_sweep(3, 3, 7, 3, 0, P_ERRS, R_ALWAYS, 1'b0);
        run_sweep(1, 2, 0, 1, 1, P_RAND, R_NEVER, 1'b1);
        run_sweep(1, 2, 0, 1, 1, P_RAND, R_RAND, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run_sweep($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 12),
                      $urandom_range(0, 12) % 4 + 10, $urandom_range(0, 8), P_RAND, R_RAND, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
